// File: rtl/modn_updown_counter.sv
// modn_updown_counter: modulo-m up/down counter with a runtime-programmable
// modulus, enable prescaler, synchronous clear/load, a terminal-count pulse
// and a sticky overflow flag.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                count enable; low freezes count and prescaler
//   up_dn             1 = count up, 0 = count down
//   clr               synchronous clear of count and prescaler
//   load, load_val    synchronous load (clamped to m-1)
//   mod_we, mod_val   write new modulus (values below 2 clamp to 2)
//   presc             step once every presc+1 enabled cycles
//   ovf_clr           clear sticky overflow flag (a coincident wrap wins)
//   count             current count, 0..m-1
//   modulus           current modulus m
//   tc                one-cycle pulse on the edge a wrap occurs
//   ovf               sticky wrap flag
module modn_updown_counter #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned MOD_DEFAULT = 6,
   parameter int unsigned PRESCALE_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  mod_we,
   input  logic [WIDTH-1:0]      mod_val,
   input  logic [PRESCALE_W-1:0] presc,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      count,
   output logic [WIDTH-1:0]      modulus,
   output logic                  tc,
   output logic                  ovf
);

   localparam logic [WIDTH-1:0] MOD_RST = WIDTH'(MOD_DEFAULT);
   localparam logic [WIDTH-1:0] MOD_MIN = WIDTH'(2);

   logic [PRESCALE_W-1:0] presc_cnt;
   logic [PRESCALE_W-1:0] presc_cnt_nxt;
   logic [WIDTH-1:0]      count_nxt;
   logic [WIDTH-1:0]      modulus_nxt;
   logic [WIDTH-1:0]      mod_top;
   logic                  tick;
   logic                  wrap;
   logic                  ovf_nxt;

   // m-1 is safe at WIDTH bits because m is never below 2
   assign mod_top = modulus - WIDTH'(1);
   assign tick    = en && (presc_cnt == presc);

   // Next-state: clr > mod_we > load > tick step > hold
   always_comb begin
      count_nxt     = count;
      modulus_nxt   = modulus;
      presc_cnt_nxt = presc_cnt;
      wrap          = 1'b0;

      if (en) begin
         presc_cnt_nxt = tick ? '0 : presc_cnt + PRESCALE_W'(1);
      end

      // Modulus write is honoured even when clr also wins the count
      if (mod_we) begin
         modulus_nxt = (mod_val < MOD_MIN) ? MOD_MIN : mod_val;
      end

      if (clr || mod_we) begin
         count_nxt     = '0;
         presc_cnt_nxt = '0;
      end else if (load) begin
         count_nxt     = (load_val < modulus) ? load_val : mod_top;
         presc_cnt_nxt = '0;
      end else if (tick) begin
         if (up_dn) begin
            if (count == mod_top) begin
               count_nxt = '0;
               wrap      = 1'b1;
            end else begin
               count_nxt = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               count_nxt = mod_top;
               wrap      = 1'b1;
            end else begin
               count_nxt = count - WIDTH'(1);
            end
         end
      end

      // Set on wrap dominates a coincident clear request
      ovf_nxt = wrap ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         modulus   <= MOD_RST;
         presc_cnt <= '0;
         tc        <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         count     <= count_nxt;
         modulus   <= modulus_nxt;
         presc_cnt <= presc_cnt_nxt;
         tc        <= wrap;
         ovf       <= ovf_nxt;
      end
   end

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N up/down counter, the successor to the fixed mod-6 counter. It adds a runtime-programmable modulus, direction control, a clock-enable prescaler, synchronous clear and load, a terminal-count pulse and a sticky overflow flag. It is intended as the reusable counting core behind the team's Tiny Tapeout user designs, with ui_in/uo_out mapping done in the wrapping top.

## Interface
- WIDTH, 8: counter and modulus width, in bits (≥2).
- MOD_DEFAULT, 6: modulus loaded at reset (2 ≤ MOD_DEFAULT ≤ 2^WIDTH−1).
- PRESCALE_W, 4: prescaler compare width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; low freezes the count and prescaler.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value used by load.
- mod_we  in  1  write a new modulus.
- mod_val  in  WIDTH  new modulus.
- presc  in  PRESCALE_W  step every presc+1 enabled cycles.
- ovf_clr  in  1  clear the sticky overflow flag.
- count  out  WIDTH  current count, always in 0..m−1.
- modulus  out  WIDTH  current modulus m.
- tc  out  1  one-cycle terminal-count (wrap) pulse.
- ovf  out  1  sticky wrap flag.

## Operation
- **Reset:** count=0, prescaler p=0, m=MOD_DEFAULT, tc=0, ovf=0. Outputs take these values immediately on rst_n low, independent of clk.
- **Tick:** tick = en && (p == presc).
  - On an enabled cycle, p ← 0 if tick, else p ← p+1.
  - When en=0, p holds.
- **Action priority per edge** (highest first):
  - clr: count←0, p←0.
  - mod_we: m←max(mod_val,2), count←0, p←0. Values 0 and 1 clamp to 2.
  - load: count←(load_val < m ? load_val : m−1), p←0.
  - tick and up_dn=1: count←(count==m−1 ? 0 : count+1).
  - tick and up_dn=0: count←(count==0 ? m−1 : count−1).
  - Otherwise: hold.
- **Wrap:** a wrap is a tick step taken from m−1 upward or from 0 downward. Only tick steps wrap; clr, load and mod_we never wrap.
- **tc:** registered. tc←1 on the edge where a wrap occurs, else 0. It is high for exactly one cycle, coincident with count showing the wrapped value.
- **ovf:** ovf←1 on a wrap edge. ovf←0 when ovf_clr=1 and no wrap. If a wrap and ovf_clr coincide, set wins.
- **en=0:** clr, load and mod_we still act. No tick, no wrap.
- **Arithmetic:** unsigned WIDTH-bit. m−1 is computed at WIDTH bits, valid because m≥2.
- **Direction:** up_dn may change on any cycle and takes effect at the next tick. No state is lost.
- **Modulus output:** the modulus port reflects m.

## Timing
- Single clock domain. All control inputs are sampled on the rising edge of clk.
- count, tc, ovf and modulus are registered outputs with no combinational paths from inputs.
- Latency, control input to count:
  - 1 cycle after the edge sampling clr, load or mod_we.
  - 1 cycle after the edge sampling a tick.
- Step period: with en held high, count steps once every presc+1 cycles. The first step after reset, clr, load or mod_we comes presc+1 enabled cycles later.
- Changing presc mid-count: applies on the next compare. If p > new presc, p runs up to 2^PRESCALE_W−1, wraps to 0, then matches.
- Deasserting rst_n: the first active edge comes one cycle later. The design requires deassertion synchronous to clk.
- Reset mid-operation overrides every in-flight action. Any pending tc is dropped.

## Test plan
- **Default up count:** reset, en=1, up_dn=1, presc=0 → count 0,1,2,3,4,5,0,1…. tc=1 only in the cycle count returns to 0. ovf sets at that same point and stays set.
- **Down count and flag clear:** en=1, up_dn=0, presc=0 → count 0,5,4,3,2,1,0,5. tc pulses when count shows 5. Pulse ovf_clr in a non-wrap cycle → ovf=0. Then drive ovf_clr in a wrap cycle → ovf stays 1.
- **Prescaler and enable:**
  - presc=2 → each value is held 3 cycles.
  - Drop en for 4 cycles mid-hold → count and phase freeze, then resume with the remaining hold length.
- **Load and modulus:**
  - load_val=3 with m=6 → count=3.
  - load_val=9 → count=5.
  - mod_we with mod_val=10 while count=4 → count=0, modulus=10, up count reaches 9 then wraps.
  - mod_val=1 → modulus=2.
- **Priority:** assert clr, mod_we and load in the same cycle → count=0, modulus=mod_val. Assert load and tick together → count=load_val, no step, no tc.
- **Reset mid-operation:** drop rst_n asynchronously between edges while count=4 and a tc is due → count=0, modulus=6, tc=0 and ovf=0 immediately. The sequence restarts from 0 after release.
